inp_bcd: RTL
============

INP_BCD -- requirements
Module: inp_bcd

Interface
REQ-001 SHALL have port clock, input, 1 bit, single clock for all state, rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-003 SHALL have port ler, input, 1 bit, read request that starts one conversion.
REQ-004 SHALL have ports milE, centE, dezE, uniE, input, 4 bits each, BCD thousands/hundreds/tens/units digits.
REQ-005 SHALL have port saida, output, 32 bits, binary result, zero-extended.
REQ-006 SHALL have port ocupado, output, 1 bit, high while a conversion is in progress.
REQ-007 SHALL have port pronto, output, 1 bit, one-cycle pulse when saida has been updated.
REQ-008 SHALL have port erro, output, 1 bit, invalid-digit flag for the last conversion.

Function
REQ-009 SHALL implement FSM states OCIOSO, CONVERTE, FIM.
REQ-010 In OCIOSO with ler=1 at a clock edge, SHALL capture all four digits into a 16-bit BCD shift register, clear the 16-bit binary register, clear the 5-bit counter, and enter CONVERTE.
REQ-011 In CONVERTE, each cycle SHALL perform one reverse double-dabble step on {BCD, binary}:
- shift right 1, with the BCD LSB entering the binary MSB;
- then subtract 3 from each 4-bit BCD nibble whose value is >= 8;
- then increment the counter.
REQ-012 After exactly 16 CONVERTE cycles (counter = 15 on the last step), SHALL enter FIM.
REQ-013 In FIM, SHALL load saida with {16'b0, binary}, assert pronto for exactly that cycle, and return to OCIOSO on the next edge.
REQ-014 Latency: ler sampled at edge N SHALL give pronto=1 and the valid saida in the cycle following edge N+17.
REQ-015 ocupado SHALL be 1 in CONVERTE and FIM, and 0 in OCIOSO.
REQ-016 ler SHALL be ignored while ocupado=1; no queuing, and digits SHALL NOT be resampled.
REQ-017 Digit inputs SHALL be sampled only at the capture edge; later changes SHALL NOT affect the result.
REQ-018 saida and erro SHALL hold their values between conversions, changing only in FIM or on reset.
REQ-019 ler held high continuously SHALL start a new conversion on the first OCIOSO edge after each FIM (back-to-back period of 18 cycles).
REQ-020 For valid digits, saida SHALL equal mil*1000 + cent*100 + dez*10 + uni (range 0..9999).

Reset
REQ-021 reset_n=0 SHALL immediately force: state OCIOSO, saida=0, pronto=0, ocupado=0, erro=0, counter=0, shift registers=0.
REQ-022 Reset asserted mid-conversion SHALL abort it with no pronto pulse; after release, the block SHALL wait for a fresh ler.
REQ-023 Reset release SHALL take effect at the first clock edge with reset_n=1; ler sampled at that edge SHALL be honoured.

Configuration
REQ-024 Macro INP_BCD_DIGIT_CHECK_EN, when defined:
- any captured digit > 9 SHALL set erro=1 in FIM;
- saida SHALL be forced to 0 in that FIM;
- a conversion with all digits valid SHALL set erro=0 in FIM.
REQ-025 Without INP_BCD_DIGIT_CHECK_EN:
- erro SHALL be tied to 0;
- invalid digits SHALL be processed by the REQ-011 algorithm unchanged, with the result unspecified in meaning but deterministic.

Verification
REQ-026 Digits 1,2,3,4 with ler pulse -> ocupado high for 17 cycles, pronto one cycle, saida=32'd1234.
REQ-027 Digits 9,9,9,9 -> saida=9999. Digits 0,0,0,0 -> saida=0. Digits 0,0,0,7 -> saida=7.
REQ-028 ler pulses at cycles +1, +5 and +16 after a start -> exactly one pronto; digits changed to 5,5,5,5 at +3 -> result still from the captured digits.
REQ-029 reset_n low at cycle 8 of a 4,3,2,1 conversion -> no pronto, saida=0; a new ler for 0,0,4,2 -> saida=42.
REQ-030 With INP_BCD_DIGIT_CHECK_EN defined, digits 1,A,0,0 -> erro=1, saida=0; a following 0,0,1,0 -> erro=0, saida=10.
REQ-031 ler held high for 40 cycles with digits 2,0,2,5 -> pronto pulses at fixed 18-cycle spacing, each with saida=2025.

Source files
------------

// File: rtl/inp_bcd_if.sv
// Request/result bundle for the inp_bcd BCD-to-binary converter.
interface inp_bcd_if;
  logic        ler;
  logic [3:0]  milE;
  logic [3:0]  centE;
  logic [3:0]  dezE;
  logic [3:0]  uniE;
  logic [31:0] saida;
  logic        ocupado;
  logic        pronto;
  logic        erro;

  modport master (
    output ler, milE, centE, dezE, uniE,
    input  saida, ocupado, pronto, erro
  );

  modport slave (
    input  ler, milE, centE, dezE, uniE,
    output saida, ocupado, pronto, erro
  );
endinterface

// File: rtl/inp_bcd.sv
// Four-digit BCD to binary converter using a serial reverse double-dabble (16 steps).
// Optional invalid-digit detection is enabled by defining INP_BCD_DIGIT_CHECK_EN.
module inp_bcd (
  input logic      clock,
  input logic      reset_n,
  inp_bcd_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} state_e;

  state_e      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bin_q, bin_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] saida_q, saida_d;
  logic        pronto_q, pronto_d;
  logic [15:0] step_bcd;
  logic [15:0] step_bin;

`ifdef INP_BCD_DIGIT_CHECK_EN
  logic bad_q, bad_d;
  logic erro_q, erro_d;
`endif

  // One reverse double-dabble step: shift {bcd, bin} right, then correct nibbles >= 8.
  always_comb begin
    logic [15:0] shifted;
    shifted  = {1'b0, bcd_q[15:1]};
    step_bin = {bcd_q[0], bin_q[15:1]};
    step_bcd = shifted;
    for (int i = 0; i < 4; i++) begin
      if (shifted[4*i+3]) begin
        step_bcd[4*i +: 4] = shifted[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    saida_d  = saida_q;
    pronto_d = 1'b0;
`ifdef INP_BCD_DIGIT_CHECK_EN
    bad_d    = bad_q;
    erro_d   = erro_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (bus.ler) begin
          bcd_d   = {bus.milE, bus.centE, bus.dezE, bus.uniE};
          bin_d   = 16'd0;
          cnt_d   = 5'd0;
          state_d = CONVERTE;
`ifdef INP_BCD_DIGIT_CHECK_EN
          bad_d   = (bus.milE > 4'd9) || (bus.centE > 4'd9) ||
                    (bus.dezE > 4'd9) || (bus.uniE > 4'd9);
`endif
        end
      end
      CONVERTE: begin
        bcd_d = step_bcd;
        bin_d = step_bin;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = FIM;
        end
      end
      FIM: begin
        // Result and pronto are registered here, so they appear the cycle after FIM.
        saida_d  = {16'd0, bin_q};
        pronto_d = 1'b1;
        state_d  = OCIOSO;
`ifdef INP_BCD_DIGIT_CHECK_EN
        erro_d   = bad_q;
        if (bad_q) begin
          saida_d = 32'd0;
        end
`endif
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OCIOSO;
      bcd_q    <= 16'd0;
      bin_q    <= 16'd0;
      cnt_q    <= 5'd0;
      saida_q  <= 32'd0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      saida_q  <= saida_d;
      pronto_q <= pronto_d;
    end
  end

`ifdef INP_BCD_DIGIT_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bad_q  <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      bad_q  <= bad_d;
      erro_q <= erro_d;
    end
  end

  assign bus.erro = erro_q;
`else
  assign bus.erro = 1'b0;
`endif

  assign bus.saida   = saida_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = (state_q != OCIOSO);

endmodule
